pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 36 +++
 rtl/config.sv | 5 +
 rtl/pipe_ctrl_perf.sv | 32 +++
 rtl/stl_reg.sv | 26 ++
 rtl/pipe_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 237 +++++++++++++++++++++++
 6 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: controller state encoding, widths and the load-use helper.
// Revision: 1.0
`default_nettype none
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

package pipe_ctrl_pkg;

   localparam int CPU_W = `CPU_WIDTH;
   localparam int REG_W = 5;
   localparam int ST_W  = 2;

   typedef logic [ST_W-1:0] state_t;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_KILL  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [CPU_W-1:0] CNT_ONE = {{(CPU_W-1){1'b0}}, 1'b1};

   typedef struct packed {
      logic wen;
      logic bubble;
   } stage_ctl_t;

   // x0 is hardwired zero, so a write to it can never create a dependency.
   function automatic logic src_hit(input logic             en,
                                    input logic [REG_W-1:0] rs,
                                    input logic [REG_W-1:0] rd);
      return en && (rs == rd) && (rd != '0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/config.sv
// config: global datapath width shared by the pipeline control slice.
// Revision: 1.0
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

// File: rtl/pipe_ctrl_perf.sv
// pipe_ctrl_perf: wrapping stall-cycle and redirect counters for pipe_ctrl.
// Revision: 1.0
`default_nettype none

module pipe_ctrl_perf
   import pipe_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             flush,
   output logic [CPU_W-1:0] stall_cnt,
   output logic [CPU_W-1:0] flush_cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         if (flush) begin
            flush_cnt <= flush_cnt + CNT_ONE;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/stl_reg.sv
// stl_reg: generic write-enabled register with asynchronous active-low reset.
// Revision: 1.0
`default_nettype none

module stl_reg #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wen,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= RST_VAL;
      end else if (wen) begin
         dout <= din;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: zero-latency 5-stage hazard/flush/fence.i controller.
// Revision: 1.0 -- optional counters under PIPE_CTRL_PERF_EN.
`default_nettype none

module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [REG_W-1:0] i_idu_rs1_id,
   input  logic [REG_W-1:0] i_idu_rs2_id,
   input  logic             i_idu_rs1_en,
   input  logic             i_idu_rs2_en,
   input  logic             i_idu_fencei,
   input  logic             i_exu_ld_en,
   input  logic [REG_W-1:0] i_exu_rd_id,
   input  logic             i_exu_brch,
   input  logic             i_ifu_ready,
   input  logic             i_lsu_req,
   input  logic             i_lsu_ready,
   output logic             o_pc_wen,
   output logic             o_if_id_wen,
   output logic             o_if_id_bubble,
   output logic             o_id_ex_wen,
   output logic             o_id_ex_bubble,
   output logic             o_ex_mem_wen,
   output logic             o_ex_mem_bubble,
   output logic             o_mem_wb_wen,
   output logic             o_mem_wb_bubble
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [`CPU_WIDTH-1:0] o_stall_cnt,
   output logic [`CPU_WIDTH-1:0] o_flush_cnt
`endif
);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] valid_q;
   logic [2:0] valid_d;
   logic       v_ex;
   logic       v_mem;
   logic       v_wb;

   logic       mem_wait;
   logic       load_use;
   logic       pipe_busy;
   logic       fence_hold;

   logic       pc_wen;
   stage_ctl_t if_id;
   stage_ctl_t id_ex;
   stage_ctl_t ex_mem;
   stage_ctl_t mem_wb;

   assign v_ex  = valid_q[2];
   assign v_mem = valid_q[1];
   assign v_wb  = valid_q[0];

   assign mem_wait   = i_lsu_req & ~i_lsu_ready;
   assign load_use   = i_exu_ld_en &
                       (src_hit(i_idu_rs1_en, i_idu_rs1_id, i_exu_rd_id) |
                        src_hit(i_idu_rs2_en, i_idu_rs2_id, i_exu_rd_id));
   assign pipe_busy  = v_ex | v_mem | v_wb;
   assign fence_hold = (state == ST_DRAIN) | i_idu_fencei;

   always_comb begin
      state_nxt = state;
      pc_wen    = 1'b1;
      if_id     = '{wen: 1'b1, bubble: 1'b0};
      id_ex     = '{wen: 1'b1, bubble: 1'b0};
      ex_mem    = '{wen: 1'b1, bubble: 1'b0};
      mem_wb    = '{wen: 1'b1, bubble: 1'b0};

      if (mem_wait) begin
         pc_wen        = 1'b0;
         if_id.wen     = 1'b0;
         id_ex.wen     = 1'b0;
         ex_mem.wen    = 1'b0;
         mem_wb.bubble = 1'b1;
      end else if (i_exu_brch) begin
         if_id.bubble = 1'b1;
         id_ex.bubble = 1'b1;
         // A redirect out of DRAIN resumes directly; elsewhere a pending
         // wrong-path fetch must be swallowed first.
         state_nxt    = ((state == ST_DRAIN) || i_ifu_ready) ? ST_RUN : ST_KILL;
      end else if (state == ST_KILL) begin
         pc_wen       = 1'b0;
         if_id.bubble = 1'b1;
         id_ex.bubble = 1'b1;
         if (i_ifu_ready) begin
            state_nxt = ST_RUN;
         end
      end else if (fence_hold && pipe_busy) begin
         pc_wen       = 1'b0;
         if_id.wen    = 1'b0;
         id_ex.bubble = 1'b1;
         state_nxt    = ST_DRAIN;
      end else begin
         // Normal issue; also the single release cycle of a drained fence.i.
         state_nxt = ST_RUN;
         if (load_use) begin
            pc_wen       = 1'b0;
            if_id.wen    = 1'b0;
            id_ex.bubble = 1'b1;
         end else if (!i_ifu_ready) begin
            pc_wen       = 1'b0;
            if_id.bubble = 1'b1;
         end
      end
   end

   assign o_pc_wen        = i_rst_n & pc_wen;
   assign o_if_id_wen     = i_rst_n & if_id.wen;
   assign o_if_id_bubble  = i_rst_n & if_id.bubble;
   assign o_id_ex_wen     = i_rst_n & id_ex.wen;
   assign o_id_ex_bubble  = i_rst_n & id_ex.bubble;
   assign o_ex_mem_wen    = i_rst_n & ex_mem.wen;
   assign o_ex_mem_bubble = i_rst_n & ex_mem.bubble;
   assign o_mem_wb_wen    = i_rst_n & mem_wb.wen;
   assign o_mem_wb_bubble = i_rst_n & mem_wb.bubble;

   // Valid bits follow the stage registers they shadow.
   assign valid_d[2] = o_id_ex_wen  ? ~o_id_ex_bubble          : v_ex;
   assign valid_d[1] = o_ex_mem_wen ? (~o_ex_mem_bubble & v_ex)  : v_mem;
   assign valid_d[0] = o_mem_wb_wen ? (~o_mem_wb_bubble & v_mem) : v_wb;

   stl_reg #(
      .WIDTH   (ST_W),
      .RST_VAL (ST_RUN)
   ) u_state_reg (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .wen   (1'b1),
      .din   (state_nxt),
      .dout  (state)
   );

   stl_reg #(
      .WIDTH   (3),
      .RST_VAL (3'b000)
   ) u_valid_reg (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .wen   (1'b1),
      .din   (valid_d),
      .dout  (valid_q)
   );

`ifdef PIPE_CTRL_PERF_EN
   pipe_ctrl_perf u_perf (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .stall     (~o_pc_wen),
      .flush     (i_exu_brch & ~mem_wait),
      .stall_cnt (o_stall_cnt),
      .flush_cnt (o_flush_cnt)
   );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed stimulus with a queued-expectation scoreboard for pipe_ctrl.
`default_nettype none
`timescale 1ns/1ps
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module tb_pipe_ctrl;

   // {pc, if_id wen/bub, id_ex wen/bub, ex_mem wen/bub, mem_wb wen/bub}
   localparam logic [8:0] E_RST   = 9'b000000000;
   localparam logic [8:0] E_RUN   = 9'b110101010;
   localparam logic [8:0] E_MEMW  = 9'b000000011;
   localparam logic [8:0] E_REDIR = 9'b111111010;
   localparam logic [8:0] E_LDUSE = 9'b000111010;
   localparam logic [8:0] E_FWAIT = 9'b011101010;
   localparam logic [8:0] E_KILL  = 9'b011111010;
   localparam logic [8:0] E_DRAIN = 9'b000111010;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       rs1_en;
      logic       rs2_en;
      logic       fencei;
      logic       ld_en;
      logic [4:0] rd;
      logic       brch;
      logic       ifu_ready;
      logic       lsu_req;
      logic       lsu_ready;
   } stim_t;

   typedef struct {
      logic [8:0]  ctrl;
      bit          chk_cnt;
      int unsigned stall;
      int unsigned flush;
      string       name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] rs1_id = '0, rs2_id = '0, rd_id = '0;
   logic       rs1_en = 1'b0, rs2_en = 1'b0, fencei = 1'b0, ld_en = 1'b0;
   logic       brch = 1'b0, ifu_ready = 1'b1, lsu_req = 1'b0, lsu_ready = 1'b0;
   logic       pc_wen, if_id_wen, if_id_bubble, id_ex_wen, id_ex_bubble;
   logic       ex_mem_wen, ex_mem_bubble, mem_wb_wen, mem_wb_bubble;
`ifdef PIPE_CTRL_PERF_EN
   logic [`CPU_WIDTH-1:0] stall_cnt, flush_cnt;
`endif

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_idu_rs1_id    (rs1_id),
      .i_idu_rs2_id    (rs2_id),
      .i_idu_rs1_en    (rs1_en),
      .i_idu_rs2_en    (rs2_en),
      .i_idu_fencei    (fencei),
      .i_exu_ld_en     (ld_en),
      .i_exu_rd_id     (rd_id),
      .i_exu_brch      (brch),
      .i_ifu_ready     (ifu_ready),
      .i_lsu_req       (lsu_req),
      .i_lsu_ready     (lsu_ready),
      .o_pc_wen        (pc_wen),
      .o_if_id_wen     (if_id_wen),
      .o_if_id_bubble  (if_id_bubble),
      .o_id_ex_wen     (id_ex_wen),
      .o_id_ex_bubble  (id_ex_bubble),
      .o_ex_mem_wen    (ex_mem_wen),
      .o_ex_mem_bubble (ex_mem_bubble),
      .o_mem_wb_wen    (mem_wb_wen),
      .o_mem_wb_bubble (mem_wb_bubble)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .o_stall_cnt     (stall_cnt),
      .o_flush_cnt     (flush_cnt)
`endif
   );

   function automatic stim_t idle();
      stim_t s;
      s           = '0;
      s.ifu_ready = 1'b1;
      return s;
   endfunction

   task automatic drive(input stim_t s, input logic rst_v, input logic [8:0] e,
                        input string nm, input bit chk, input int unsigned es,
                        input int unsigned ef);
      exp_t x;
      @(posedge clk);
      #1;
      rst_n     = rst_v;
      rs1_id    = s.rs1;
      rs2_id    = s.rs2;
      rs1_en    = s.rs1_en;
      rs2_en    = s.rs2_en;
      fencei    = s.fencei;
      ld_en     = s.ld_en;
      rd_id     = s.rd;
      brch      = s.brch;
      ifu_ready = s.ifu_ready;
      lsu_req   = s.lsu_req;
      lsu_ready = s.lsu_ready;
      x.ctrl    = e;
      x.chk_cnt = chk;
      x.stall   = es;
      x.flush   = ef;
      x.name    = nm;
      exp_q.push_back(x);
   endtask

   task automatic run(input stim_t s, input logic [8:0] e, input string nm);
      drive(s, 1'b1, e, nm, 1'b0, 0, 0);
   endtask

   // Monitor: one expectation per cycle, compared mid-cycle.
   initial begin
      exp_t       x;
      logic [8:0] got;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            x   = exp_q.pop_front();
            got = {pc_wen, if_id_wen, if_id_bubble, id_ex_wen, id_ex_bubble,
                   ex_mem_wen, ex_mem_bubble, mem_wb_wen, mem_wb_bubble};
            checks++;
            if (got !== x.ctrl) begin
               failures++;
               $display("FAIL %s: got %b expected %b", x.name, got, x.ctrl);
            end
`ifdef PIPE_CTRL_PERF_EN
            if (x.chk_cnt) begin
               checks++;
               if (stall_cnt !== `CPU_WIDTH'(x.stall) || flush_cnt !== `CPU_WIDTH'(x.flush)) begin
                  failures++;
                  $display("FAIL %s_cnt: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                           x.name, stall_cnt, flush_cnt, x.stall, x.flush);
               end
            end
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      stim_t s;
      s = idle(); s.brch = 1'b1;
      drive(s, 1'b0, E_RST, "reset_0", 1'b0, 0, 0);
      drive(s, 1'b0, E_RST, "reset_1", 1'b0, 0, 0);
      for (int i = 0; i < 3; i++) run(idle(), E_RUN, "run_fill");

      s = idle(); s.ld_en = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.rs1_en = 1'b1;
      run(s, E_LDUSE, "ld_use_rs1");
      s = idle(); s.ld_en = 1'b1; s.rd = 5'd0; s.rs1 = 5'd0; s.rs1_en = 1'b1;
      run(s, E_RUN, "ld_x0");
      s = idle(); s.ld_en = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.rs2 = 5'd7;
      run(s, E_RUN, "ld_src_disabled");
      s = idle(); s.ld_en = 1'b1; s.rd = 5'd9; s.rs2 = 5'd9; s.rs2_en = 1'b1;
      run(s, E_LDUSE, "ld_use_rs2");

      s = idle(); s.ifu_ready = 1'b0;
      run(s, E_FWAIT, "fetch_wait");
      s.brch = 1'b1;
      run(s, E_REDIR, "redirect_to_kill");
      s = idle(); s.ifu_ready = 1'b0;
      run(s, E_KILL, "kill_wait");
      run(idle(), E_KILL, "kill_discard");
      run(idle(), E_RUN, "kill_exit");
      run(idle(), E_RUN, "run_a");
      run(idle(), E_RUN, "run_b");

      s = idle(); s.lsu_req = 1'b1; s.brch = 1'b1;
      for (int i = 0; i < 3; i++) run(s, E_MEMW, "mem_wait_brch");
      s.lsu_ready = 1'b1;
      run(s, E_REDIR, "mem_done_redirect");
      for (int i = 0; i < 3; i++) run(idle(), E_RUN, "run_refill");

      s = idle(); s.fencei = 1'b1;
      for (int i = 0; i < 3; i++) run(s, E_DRAIN, "fence_drain");
      run(s, E_RUN, "fence_release");
      run(idle(), E_RUN, "after_fence");

      run(s, E_DRAIN, "drain_enter");
      s.lsu_req = 1'b1;
      run(s, E_MEMW, "drain_mem_wait");
      s.lsu_req = 1'b0;
      run(s, E_DRAIN, "drain_resume");
      s.brch = 1'b1; s.ifu_ready = 1'b0;
      run(s, E_REDIR, "drain_redirect");
      s = idle(); s.ifu_ready = 1'b0;
      run(s, E_FWAIT, "post_drain_redirect_run");
      run(idle(), E_RUN, "run_c");

      s = idle(); s.fencei = 1'b1;
      run(s, E_DRAIN, "drain2_enter");
      run(s, E_DRAIN, "drain2_hold");
      drive(s, 1'b0, E_RST, "reset_in_drain", 1'b0, 0, 0);
      drive(s, 1'b0, E_RST, "reset_in_drain_hold", 1'b0, 0, 0);
      run(idle(), E_RUN, "reset_release");

      s = idle(); s.ifu_ready = 1'b0;
      for (int i = 0; i < 4; i++) run(s, E_FWAIT, "stall_cycle");
      s = idle(); s.brch = 1'b1;
      run(s, E_REDIR, "flush_1");
      run(s, E_REDIR, "flush_2");
      drive(idle(), 1'b1, E_RUN, "perf", 1'b1, 4, 2);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
